// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage and the hazard unit.
//   flush_e : PCFlush / IFIDFlush control encodings
//   pcsrc_e : ID-stage redirect select encodings
//   RESET_PC_DEF : default PC after reset
//   sel_next_pc : next-PC priority selection
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FL_NORMAL = 2'b00,
    FL_FLUSH  = 2'b01,
    FL_HOLD   = 2'b10,
    FL_HOLD_X = 2'b11
  } flush_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ   = 2'b00,
    PCSRC_JUMP  = 2'b01,
    PCSRC_JR    = 2'b10,
    PCSRC_SEQ_X = 2'b11
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  // A taken EX branch is older than any ID redirect, so it wins.
  function automatic logic [31:0] sel_next_pc(
    input logic        br_taken,
    input logic [1:0]  pcsrc,
    input logic [31:0] br_target,
    input logic [31:0] j_target,
    input logic [31:0] r_target,
    input logic [31:0] pc_plus4
  );
    logic [31:0] res;
    res = pc_plus4;
    if (br_taken)                 res = br_target;
    else if (pcsrc == PCSRC_JUMP) res = j_target;
    else if (pcsrc == PCSRC_JR)   res = r_target;
    return res;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Link between the fetch-stage control logic and the PC register.
//   hold    : PC keeps its value this cycle
//   pc_next : value loaded into the PC when not holding
//   pc      : current PC register value
interface fetch_stage_if;
  logic        hold;
  logic [31:0] pc_next;
  logic [31:0] pc;

  modport master (output hold, output pc_next, input pc);
  modport slave  (input hold, input pc_next, output pc);
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter register with hold and synchronous reset.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, loads RESET_PC
//   pc_if  : slave side of fetch_stage_if (hold, pc_next in; pc out)
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic   clk,
  input  logic   reset,
  fetch_stage_if.slave pc_if
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!pc_if.hold) pc_d = pc_if.pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_if.pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC selection, IF/ID pipeline register
// and stall/flush event counters.
//   clk, reset            : clock, synchronous active-high reset
//   PCFlush               : 00 update PC, otherwise hold
//   IFIDFlush             : 00 load, 01 flush to bubble, 10/11 hold
//   PCSrcID               : ID redirect select (01 jump, 10 jr)
//   branch_EX, zero       : EX branch taken when both set
//   branch_target, jump_target, jr_target : redirect destinations
//   imem_instr / imem_addr: combinational instruction memory port
//   IFID_*                : registered instruction, PC+4 and valid for ID
//   stall_count, flush_count : free-running event counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCFlush,
  input  logic [1:0]  IFIDFlush,
  input  logic [1:0]  PCSrcID,
  input  logic        branch_EX,
  input  logic        zero,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  fetch_stage_if pc_bus ();

  logic [31:0] pc_plus4;
  logic        pc_hold;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        vld_q,   vld_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // 32-bit add wraps naturally at 2^32.
  assign pc_plus4 = pc_bus.pc + 32'd4;
  assign pc_hold  = (PCFlush != FL_NORMAL);

  assign pc_bus.hold    = pc_hold;
  assign pc_bus.pc_next = sel_next_pc(branch_EX && zero, PCSrcID, branch_target,
                                      jump_target, jr_target, pc_plus4);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .pc_if (pc_bus.slave)
  );

  // imem_addr comes straight from the register: no input-to-address path.
  assign imem_addr = pc_bus.pc;

  // IF/ID register next state
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    vld_d   = vld_q;
    unique case (flush_e'(IFIDFlush))
      FL_NORMAL: begin
        instr_d = imem_instr;
        pc4_d   = pc_plus4;
        vld_d   = 1'b1;
      end
      FL_FLUSH: begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        vld_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q + {31'h0, pc_hold};
    flush_d = flush_q + {31'h0, (IFIDFlush == FL_FLUSH)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      vld_q   <= 1'b0;
      stall_q <= 32'h0;
      flush_q <= 32'h0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pc4_q;
  assign IFID_Valid       = vld_q;
  assign stall_count      = stall_q;
  assign flush_count      = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCFlush, IFIDFlush, PCSrcID;
  logic        branch_EX, zero;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] imem_instr, imem_addr;
  logic [31:0] IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_vld;

  always #5 clk = ~clk;

  // Instruction memory: a pure function of the address.
  assign imem_instr = imem_addr ^ MASK;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk              (clk),
    .reset            (reset),
    .PCFlush          (PCFlush),
    .IFIDFlush        (IFIDFlush),
    .PCSrcID          (PCSrcID),
    .branch_EX        (branch_EX),
    .zero             (zero),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .jr_target        (jr_target),
    .imem_instr       (imem_instr),
    .imem_addr        (imem_addr),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, advance the model across the edge,
  // then compare every observable output 1 time unit after the edge.
  task automatic step(input logic rst, input logic [1:0] pcf, input logic [1:0] ifd,
                      input logic [1:0] src, input logic bex, input logic z,
                      input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    logic [31:0] target;
    reset = rst; PCFlush = pcf; IFIDFlush = ifd; PCSrcID = src;
    branch_EX = bex; zero = z; branch_target = bt; jump_target = jt; jr_target = jrt;
    @(posedge clk);
    if (rst) begin
      m_pc = RPC; m_instr = 0; m_pc4 = 0; m_vld = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (bex && z)        target = bt;
      else if (src == 2'd1) target = jt;
      else if (src == 2'd2) target = jrt;
      else                  target = m_pc + 32'd4;
      if (ifd == 2'd0) begin
        m_instr = m_pc ^ MASK; m_pc4 = m_pc + 32'd4; m_vld = 1;
      end else if (ifd == 2'd1) begin
        m_instr = 0; m_pc4 = 0; m_vld = 0; m_flush = m_flush + 1;
      end
      if (pcf == 2'd0) m_pc = target;
      else             m_stall = m_stall + 1;
    end
    #1;
    chk("imem_addr",   imem_addr,        m_pc);
    chk("ifid_instr",  IFID_Instruction, m_instr);
    chk("ifid_pc4",    IFID_PCPlus4,     m_pc4);
    chk("ifid_valid",  {31'h0, IFID_Valid}, {31'h0, m_vld});
    chk("stall_count", stall_count,      m_stall);
    chk("flush_count", flush_count,      m_flush);
  endtask

  task automatic seq(input logic [1:0] pcf, input logic [1:0] ifd);
    step(1'b0, pcf, ifd, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset release: fetch from 400000, 400004, 400008
    step(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("rst_pc", imem_addr, 32'h0040_0000);
    chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);
    seq(2'd0, 2'd0);
    chk("rel_pc1", imem_addr, 32'h0040_0004);
    chk("rel_pc4_1", IFID_PCPlus4, 32'h0040_0004);
    chk("rel_valid1", {31'h0, IFID_Valid}, 32'h1);
    seq(2'd0, 2'd0);
    chk("rel_pc2", imem_addr, 32'h0040_0008);
    chk("rel_pc4_2", IFID_PCPlus4, 32'h0040_0008);
    seq(2'd0, 2'd0);
    seq(2'd0, 2'd0);
    chk("at_400010", imem_addr, 32'h0040_0010);

    // Load-use stall
    seq(2'd2, 2'd2);
    chk("stall_pc", imem_addr, 32'h0040_0010);
    chk("stall_ifid_pc4", IFID_PCPlus4, 32'h0040_0010);
    chk("stall_cnt", stall_count, 32'd1);

    // Taken branch with IF/ID flush
    step(1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 32'h0040_0100, 32'h0, 32'h0);
    chk("br_pc", imem_addr, 32'h0040_0100);
    chk("br_instr", IFID_Instruction, 32'h0);
    chk("br_valid", {31'h0, IFID_Valid}, 32'h0);
    chk("br_flush", flush_count, 32'd1);

    // Branch beats jump
    step(1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0040_0180, 32'h0040_0200, 32'h0);
    chk("prio_pc", imem_addr, 32'h0040_0180);
    // Jump alone when branch not taken
    step(1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0040_0180, 32'h0040_0200, 32'h0);
    chk("jump_pc", imem_addr, 32'h0040_0200);

    // Hold dominates redirect, then redirect takes effect
    step(1'b0, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0300);
    chk("hold_pc", imem_addr, 32'h0040_0200);
    step(1'b0, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0300);
    chk("hold01_pc", imem_addr, 32'h0040_0200);
    step(1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0300);
    chk("jr_pc", imem_addr, 32'h0040_0300);

    // Wrap at top of address space
    step(1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    seq(2'd0, 2'd0);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc4", IFID_PCPlus4, 32'h0);
    chk("wrap_valid", {31'h0, IFID_Valid}, 32'h1);

    // Reset in the middle of a stall with a redirect pending
    step(1'b1, 2'd2, 2'd1, 2'd1, 1'b1, 1'b1, 32'h1234_5670, 32'h0, 32'h0);
    chk("midrst_pc", imem_addr, RPC);
    chk("midrst_stall", stall_count, 32'h0);
    chk("midrst_flush", flush_count, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
